acc_drain_quant: RTL and testbench

- Downstream stage of the systolic-array accumulator.
- When the accumulator raises its full flag, this block snapshots the accumulated 32-bit values.
- Each value is requantized (rounding arithmetic right shift, saturation to signed 8-bit) and written one entry at a time into the unified buffer over a valid/ready write port.
- Raises a one-cycle done pulse when the drain completes.

---
 rtl/acc_drain_quant.sv | 210 +++++++++++++++++++++
 tb/tb_acc_drain_quant.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_drain_quant.sv
// acc_drain_quant: drains accumulator entries into the unified buffer.
// When acc_full rises, the accumulator entries are snapshotted. Each entry is
// requantized (rounding arithmetic right shift, saturate to signed OUT_W) and
// written one at a time over a valid/ready write port. A one-cycle done pulse
// follows the last accepted write.
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   acc_full        accumulator full flag; its rising edge starts a drain
//   acc_data        NUM_ENTRIES packed entries, entry i at [i*ACC_W +: ACC_W]
//   base_addr       buffer address of entry 0 (sampled at trigger)
//   shift           requantization right-shift amount (sampled at trigger)
//   wr_valid/ready  write handshake; wr_addr/wr_data are the write payload
//   busy            high whenever the FSM is not idle
//   done            one-cycle pulse after the last write is accepted
//   overrun         sticky; a trigger arrived while busy
//   sat_count       entries clamped in the current/last drain (saturating)
//
// Build option: define ACT_RELU_EN to zero negative entries before rounding
// (fused ReLU). Without it, values pass through signed.

module acc_drain_quant #(
  parameter int unsigned NUM_ENTRIES = 2,
  parameter int unsigned ACC_W       = 32,
  parameter int unsigned OUT_W       = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned SHIFT_W     = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         acc_full,
  input  logic [NUM_ENTRIES*ACC_W-1:0] acc_data,
  input  logic [ADDR_W-1:0]            base_addr,
  input  logic [SHIFT_W-1:0]           shift,
  output logic                         wr_valid,
  input  logic                         wr_ready,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [OUT_W-1:0]             wr_data,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun,
  output logic [7:0]                   sat_count
);

  localparam int unsigned IDX_W  = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int unsigned EXT_W  = ACC_W + 1;
  localparam int unsigned DATA_W = NUM_ENTRIES * ACC_W;
  localparam int unsigned HI_W   = EXT_W - OUT_W + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] WRITE   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]         state_q,     state_d;
  logic [IDX_W-1:0]   idx_q,       idx_d;
  logic               acc_full_q,  acc_full_d;
  logic [DATA_W-1:0]  snap_q,      snap_d;
  logic [ADDR_W-1:0]  base_q,      base_d;
  logic [SHIFT_W-1:0] shift_q,     shift_d;
  logic               wr_valid_q,  wr_valid_d;
  logic [ADDR_W-1:0]  wr_addr_q,   wr_addr_d;
  logic [OUT_W-1:0]   wr_data_q,   wr_data_d;
  logic               busy_q,      busy_d;
  logic               done_q,      done_d;
  logic               overrun_q,   overrun_d;
  logic [7:0]         sat_cnt_q,   sat_cnt_d;

  logic                    trigger;
  logic [ACC_W-1:0]        entry;
  logic signed [EXT_W-1:0] ext;
  logic signed [EXT_W-1:0] rnd_sum;
  logic signed [EXT_W-1:0] res;
  logic [SHIFT_W-1:0]      sh_eff;
  logic [HI_W-1:0]         hi;
  logic                    q_sat;
  logic [OUT_W-1:0]        q_data;

  // Requantize the selected snapshot entry; one extra bit keeps the rounding
  // add from overflowing.
  always_comb begin
    entry = snap_q[32'(idx_q)*ACC_W +: ACC_W];
`ifdef ACT_RELU_EN
    if (entry[ACC_W-1]) begin
      entry = '0;
    end
`endif
    ext     = $signed({entry[ACC_W-1], entry});
    sh_eff  = (32'(shift_q) >= ACC_W) ? SHIFT_W'(ACC_W - 1) : shift_q;
    rnd_sum = ext;
    res     = ext;
    if (sh_eff != '0) begin
      rnd_sum = ext + (EXT_W'(1) << (sh_eff - SHIFT_W'(1)));
      res     = rnd_sum >>> sh_eff;
    end
    // Result fits in OUT_W iff all bits from the OUT_W sign bit upward agree.
    hi     = res[EXT_W-1:OUT_W-1];
    q_sat  = !((&hi) || !(|hi));
    q_data = res[OUT_W-1:0];
    if (q_sat) begin
      q_data = res[EXT_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_full_d = acc_full;
    snap_d     = snap_q;
    base_d     = base_q;
    shift_d    = shift_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    overrun_d  = overrun_q;
    sat_cnt_d  = sat_cnt_q;
    trigger    = acc_full && !acc_full_q;

    if (trigger && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (trigger) begin
          snap_d    = acc_data;
          base_d    = base_addr;
          shift_d   = shift;
          idx_d     = '0;
          sat_cnt_d = '0;
          state_d   = CONVERT;
        end
      end
      CONVERT: begin
        wr_data_d  = q_data;
        wr_addr_d  = base_q + ADDR_W'(idx_q);
        wr_valid_d = 1'b1;
        if (q_sat && (sat_cnt_q != 8'hFF)) begin
          sat_cnt_d = sat_cnt_q + 8'd1;
        end
        state_d = WRITE;
      end
      WRITE: begin
        if (wr_valid_q && wr_ready) begin
          wr_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = CONVERT;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      acc_full_q <= 1'b0;
      snap_q     <= '0;
      base_q     <= '0;
      shift_q    <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      sat_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_full_q <= acc_full_d;
      snap_q     <= snap_d;
      base_q     <= base_d;
      shift_q    <= shift_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;
  assign sat_count = sat_cnt_q;

endmodule

// File: tb/tb_acc_drain_quant.sv
// tb_acc_drain_quant: randomized and directed drains of acc_drain_quant
// checked against an arithmetic reference model of the requantizer.

module tb_acc_drain_quant;

  logic        clk;
  logic        reset;
  logic        acc_full;
  logic [63:0] acc_data;
  logic [7:0]  base_addr;
  logic [4:0]  shift;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;
  logic        overrun;
  logic [7:0]  sat_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [15:0] exp_q[$];
  bit          exp_ov = 1'b0;

  logic        prev_pend = 1'b0;
  logic [7:0]  prev_addr = '0;
  logic [7:0]  prev_data = '0;

  acc_drain_quant dut (
    .clk       (clk),
    .reset     (reset),
    .acc_full  (acc_full),
    .acc_data  (acc_data),
    .base_addr (base_addr),
    .shift     (shift),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun),
    .sat_count (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference requantizer: round half up via floor((x + p/2) / p), then clamp.
  function automatic void qmodel(input logic [31:0] raw, input int unsigned sh_in,
                                 output logic [7:0] d, output bit s);
    longint x;
    longint p;
    longint r;
    longint fl;
    int unsigned sh;
    sh = (sh_in > 31) ? 31 : sh_in;
    x  = longint'($signed(raw));
`ifdef ACT_RELU_EN
    if (x < 0) x = 0;
`endif
    if (sh == 0) begin
      fl = x;
    end else begin
      p  = 64'sd1 << sh;
      r  = x + p / 2;
      fl = r / p;
      if ((r < 0) && ((r % p) != 0)) fl = fl - 1;
    end
    s = 1'b0;
    if (fl > 127) begin
      fl = 127;
      s  = 1'b1;
    end else if (fl < -128) begin
      fl = -128;
      s  = 1'b1;
    end
    d = fl[7:0];
  endfunction

  // Write monitor: accepted writes are compared in order; stalled payloads must hold.
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_pend && wr_valid) begin
        chk("hold_addr", 32'(wr_addr), 32'(prev_addr));
        chk("hold_data", 32'(wr_data), 32'(prev_data));
      end
      if (wr_valid && wr_ready) begin
        if (exp_q.size() == 0) begin
          chk("wr_unexpected", 32'(1), 32'(0));
        end else begin
          chk("wr_addr", 32'(wr_addr), 32'(exp_q[0][15:8]));
          chk("wr_data", 32'(wr_data), 32'(exp_q[0][7:0]));
          void'(exp_q.pop_front());
        end
      end
    end
    prev_pend <= wr_valid && !wr_ready;
    prev_addr <= wr_addr;
    prev_data <= wr_data;
  end

  // mode 0: ready tied high; 1: random ready; 2: ready low for 3 cycles on first write.
  // hold: cycles acc_full stays high; retrig: produce a second rising edge during WRITE.
  task automatic drain(input logic [31:0] e0, input logic [31:0] e1, input logic [7:0] base,
                       input logic [4:0] sh, input int mode, input int hold, input bit retrig);
    logic [7:0]  d;
    bit          s;
    int unsigned exp_sat;
    int          dones;
    exp_sat = 0;
    qmodel(e0, sh, d, s);
    exp_q.push_back({base, d});
    exp_sat += s;
    qmodel(e1, sh, d, s);
    exp_q.push_back({8'(base + 8'd1), d});
    exp_sat += s;
    if (retrig) exp_ov = 1'b1;

    acc_data  = {e1, e0};
    base_addr = base;
    shift     = sh;
    acc_full  = 1'b1;
    wr_ready  = (mode != 2);
    tick;
    chk("busy_trig", 32'(busy), 32'(1));
    chk("vld_early", 32'(wr_valid), 32'(0));
    acc_data  = {$urandom, $urandom};
    base_addr = 8'($urandom);
    shift     = 5'($urandom);
    tick;
    chk("vld_latency", 32'(wr_valid), 32'(1));

    dones = 0;
    for (int cyc = 0; cyc < hold + 60; cyc++) begin
      acc_full = retrig ? (cyc != 0) : (cyc < hold);
      case (mode)
        1: wr_ready = (cyc > 20) ? 1'b1 : ($urandom_range(0, 3) != 0);
        2: begin
          if (cyc < 3) begin
            chk("vld_stall", 32'(wr_valid), 32'(1));
            wr_ready = 1'b0;
          end else begin
            wr_ready = 1'b1;
          end
        end
        default: wr_ready = 1'b1;
      endcase
      tick;
      if (done) dones++;
    end
    acc_full = 1'b0;
    chk("done_count", 32'(dones), 32'(1));
    chk("busy_after", 32'(busy), 32'(0));
    chk("sat_count", 32'(sat_count), 32'(exp_sat));
    chk("overrun", 32'(overrun), 32'(exp_ov));
    chk("wr_missing", 32'(exp_q.size()), 32'(0));
    exp_q.delete();
    tick;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] e[2];
    reset     = 1'b1;
    acc_full  = 1'b0;
    acc_data  = '0;
    base_addr = '0;
    shift     = '0;
    wr_ready  = 1'b0;
    tick;
    tick;
    chk("rst_valid", 32'(wr_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_overrun", 32'(overrun), 32'(0));
    chk("rst_sat", 32'(sat_count), 32'(0));
    chk("rst_addr", 32'(wr_addr), 32'(0));
    chk("rst_data", 32'(wr_data), 32'(0));
    reset = 1'b0;
    tick;

    drain(32'd100, -32'sd7, 8'h10, 5'd2, 0, 0, 1'b0);
    drain(32'd1000, -32'sd1000, 8'h20, 5'd0, 0, 0, 1'b0);
    drain(32'h7FFF_FFFF, 32'h8000_0000, 8'h40, 5'd31, 0, 0, 1'b0);
    drain(32'd300, -32'sd300, 8'h05, 5'd1, 2, 0, 1'b0);
    drain(32'd6, -32'sd6, 8'hFF, 5'd2, 0, 0, 1'b0);
    drain(32'd255, -32'sd129, 8'h80, 5'd1, 0, 20, 1'b0);
    drain(32'd40, -32'sd40, 8'h33, 5'd3, 2, 0, 1'b1);

    // Async reset in WRITE abandons the drain immediately.
    acc_data  = {32'd9, 32'd1000};
    base_addr = 8'h00;
    shift     = 5'd0;
    acc_full  = 1'b1;
    wr_ready  = 1'b0;
    tick;
    tick;
    chk("pre_rst_valid", 32'(wr_valid), 32'(1));
    chk("pre_rst_sat", 32'(sat_count), 32'(1));
    #1 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(wr_valid), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_done", 32'(done), 32'(0));
    chk("arst_sat", 32'(sat_count), 32'(0));
    chk("arst_overrun", 32'(overrun), 32'(0));
    exp_ov   = 1'b0;
    wr_ready = 1'b1;
    acc_full = 1'b0;
    #1 reset = 1'b0;
    tick;
    chk("post_rst_valid", 32'(wr_valid), 32'(0));
    chk("post_rst_busy", 32'(busy), 32'(0));
    tick;

    for (int n = 0; n < 16; n++) begin
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 2))
          0:       e[k] = $urandom;
          1:       e[k] = 32'($urandom_range(0, 4095)) - 32'd2048;
          default: e[k] = $urandom_range(0, 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
        endcase
      end
      drain(e[0], e[1], 8'($urandom), 5'($urandom_range(0, 31)),
            int'($urandom_range(0, 2)), 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
